tdm_deframer: RTL and testbench

TDM_DEFRAMER -- requirements
Module: tdm_deframer

---
 rtl/tdm_pkg.sv | 26 ++
 rtl/tdm_slot_counter.sv | 37 +++
 rtl/tdm_deframer.sv | 123 ++++++++++++
 tb/tb_tdm_deframer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: TDM frame geometry and FSM states shared by transmitter and receiver
//   SLOTn_LEN / SLOTn_TERM : samples per slot and last count value of each slot
//   NUM_SLOTS, FRAME_LEN   : slots per frame, samples per frame
//   PHASE_MOD              : modulus of the count13 phase counter
//   tdm_state_t            : IDLE / HUNT / LOCKED
package tdm_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int PHASE_MOD = 13;
   localparam int SLOT0_LEN = 143;
   localparam int SLOT1_LEN = 110;
   localparam int SLOT2_LEN = 77;
   localparam int SLOT3_LEN = 44;
   localparam int FRAME_LEN = SLOT0_LEN + SLOT1_LEN + SLOT2_LEN + SLOT3_LEN;
   localparam logic [7:0] SLOT0_TERM = 8'(SLOT0_LEN - 1);
   localparam logic [7:0] SLOT1_TERM = 8'(SLOT1_LEN - 1);
   localparam logic [7:0] SLOT2_TERM = 8'(SLOT2_LEN - 1);
   localparam logic [7:0] SLOT3_TERM = 8'(SLOT3_LEN - 1);

   typedef enum logic [1:0] {IDLE, HUNT, LOCKED} tdm_state_t;

   function automatic logic [7:0] slot_term(input logic [1:0] s);
      return s == 2'd0 ? SLOT0_TERM :
             s == 2'd1 ? SLOT1_TERM :
             s == 2'd2 ? SLOT2_TERM : SLOT3_TERM;
   endfunction
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: sample/slot/phase position of the sample currently presented
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : return to frame start (count=0, slot=0, count13=0); wins over en
//   en         : advance one sample
//   count      : sample index within slot
//   slot       : slot index 0..3
//   count13    : modulo-13 phase
//   last       : count is the terminal value of the current slot
module tdm_slot_counter
   import tdm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       en,
   output logic [7:0] count,
   output logic [1:0] slot,
   output logic [3:0] count13,
   output logic       last
);
   assign last = count == slot_term(slot);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         count   <= '0;
         slot    <= '0;
         count13 <= '0;
      end else if (load) begin
         count   <= '0;
         slot    <= '0;
         count13 <= '0;
      end else if (en) begin
         count   <= last ? 8'd0 : count + 8'd1;
         slot    <= last ? slot + 2'd1 : slot;
         count13 <= count13 == 4'(PHASE_MOD - 1) ? 4'd0 : count13 + 4'd1;
      end
endmodule

// File: rtl/tdm_deframer.sv
// tdm_deframer: locks to a 4-slot TDM frame and demultiplexes samples per channel
//   clk, rst_n : clock, asynchronous active-low reset
//   holder     : stream active; low forces IDLE
//   sync       : pulse marking slot 0 sample 0; din: sample stream
//   ch_data/ch_sel/ch_valid : demultiplexed sample, its slot, strobe (1-cycle latency)
//   count/count13 : position of the presented sample; locked; frame_err pulse
//   ch_active  : per-channel activity; built only with TDM_DEFRAMER_ACTIVITY_EN,
//                otherwise constant 4'b1111
module tdm_deframer
   import tdm_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int ERR_LIMIT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              holder,
   input  logic              sync,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] ch_data,
   output logic [1:0]        ch_sel,
   output logic              ch_valid,
   output logic [7:0]        count,
   output logic [3:0]        count13,
   output logic              locked,
   output logic              frame_err,
   output logic [3:0]        ch_active
);
   localparam int MW = ERR_LIMIT < 1 ? 1 : $clog2(ERR_LIMIT + 1);

   tdm_state_t    state, nxt;
   logic [MW-1:0] mis, mis_d;
   logic [1:0]    slot;
   logic          last, wrap, hit, err, realign, load;

   // The counter always describes the sample on ch_data, so the sample being
   // sampled now sits at frame start exactly when the counter is at slot 3's end.
   tdm_slot_counter u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .en      (locked),
      .count   (count),
      .slot    (slot),
      .count13 (count13),
      .last    (last)
   );

   assign locked   = state == LOCKED;
   assign ch_valid = locked;
   assign ch_sel   = slot;
   assign wrap     = last && slot == 2'(NUM_SLOTS - 1);
   assign hit      = int'(mis) + 1 >= ERR_LIMIT;
   // Outside LOCKED the position is held at frame start so outputs read zero.
   assign load     = realign || nxt != LOCKED;

   always_comb begin
      nxt     = state;
      err     = 1'b0;
      realign = 1'b0;
      mis_d   = '0;
      case (state)
         IDLE: nxt = HUNT;
         HUNT: begin
            nxt     = sync ? LOCKED : HUNT;
            realign = sync;
         end
         LOCKED: begin
            if (sync && wrap) begin
               realign = 1'b1;
            end else if (sync || wrap) begin
               // Early sync at the limit re-acquires at once; a missing sync drops lock.
               err     = 1'b1;
               mis_d   = hit ? '0 : mis + MW'(1);
               realign = hit && sync;
               nxt     = hit && !sync ? HUNT : LOCKED;
            end else begin
               mis_d = mis;
            end
         end
         default: nxt = IDLE;
      endcase
      if (!holder) begin
         nxt     = IDLE;
         err     = 1'b0;
         realign = 1'b0;
         mis_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         mis       <= '0;
         ch_data   <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= nxt;
         mis       <= mis_d;
         ch_data   <= nxt == LOCKED ? din : '0;
         frame_err <= err;
      end

`ifdef TDM_DEFRAMER_ACTIVITY_EN
   logic acc;

   // Activity is judged on the presented samples; a slot's flag is written
   // while its last sample is on ch_data.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ch_active <= '0;
         acc       <= 1'b0;
      end else if (nxt != LOCKED) begin
         ch_active <= '0;
         acc       <= 1'b0;
      end else begin
         if (locked && last) ch_active[slot] <= acc || |ch_data;
         acc <= locked && !last && !realign && (acc || |ch_data);
      end
`else
   assign ch_active = 4'b1111;
`endif
endmodule

// File: tb/tb_tdm_deframer.sv
// tb_tdm_deframer: directed scoreboard bench for tdm_deframer
module tb_tdm_deframer;
   logic       clk, rst_n, holder, sync;
   logic [7:0] din, ch_data, count;
   logic [1:0] ch_sel;
   logic [3:0] count13, ch_active;
   logic       ch_valid, locked, frame_err;

   typedef struct {
      logic [7:0] d;
      logic [1:0] sel;
      logic [7:0] cnt;
      logic [3:0] ph;
   } exp_t;

   exp_t q[$];
   int   n_cmp, n_bad, pos, ph;

`ifdef TDM_DEFRAMER_ACTIVITY_EN
   localparam logic [3:0] ACT_RST = 4'b0000;
   localparam logic [3:0] ACT_FRM = 4'b0101;
`else
   localparam logic [3:0] ACT_RST = 4'b1111;
   localparam logic [3:0] ACT_FRM = 4'b1111;
`endif

   tdm_deframer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .holder    (holder),
      .sync      (sync),
      .din       (din),
      .ch_data   (ch_data),
      .ch_sel    (ch_sel),
      .ch_valid  (ch_valid),
      .count     (count),
      .count13   (count13),
      .locked    (locked),
      .frame_err (frame_err),
      .ch_active (ch_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] pos2sc(input int p);
      if (p < 143) return {2'd0, 8'(p)};
      if (p < 253) return {2'd1, 8'(p - 143)};
      if (p < 330) return {2'd2, 8'(p - 253)};
      return {2'd3, 8'(p - 330)};
   endfunction

   function automatic logic [7:0] dat();
      logic [9:0] sc;
      sc = pos2sc(pos);
`ifdef TDM_DEFRAMER_ACTIVITY_EN
      return (sc[9:8] == 2'd1 || sc[9:8] == 2'd3) ? 8'h00 : 8'hA5;
`else
      return 8'($urandom) ^ sc[7:0];
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic step(input bit s, input logic [7:0] d, input bit ev, input bit ee);
      exp_t e;
      logic [9:0] sc;
      sync = s;
      din  = d;
      if (ev) begin
         sc    = pos2sc(pos);
         e.d   = d;
         e.sel = sc[9:8];
         e.cnt = sc[7:0];
         e.ph  = 4'(ph);
         q.push_back(e);
      end
      @(posedge clk);
      #1;
      chk("ch_valid", ch_valid, ev);
      chk("locked", locked, ev);
      chk("frame_err", frame_err, ee);
      if (ev && q.size() > 0) begin
         e = q.pop_front();
         chk("ch_data", ch_data, e.d);
         chk("ch_sel", ch_sel, e.sel);
         chk("count", count, e.cnt);
         chk("count13", count13, e.ph);
      end else if (!ev) begin
         chk("idle_data", ch_data, 0);
         chk("idle_sel", ch_sel, 0);
         chk("idle_count", count, 0);
         chk("idle_count13", count13, 0);
      end
      pos = (pos + 1) % 374;
      ph  = (ph + 1) % 13;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(1'b0, dat(), 1'b1, 1'b0);
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; pos = 0; ph = 0;
      rst_n = 1'b0; holder = 1'b0; sync = 1'b0; din = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", ch_data, 0);
      chk("rst_sel", ch_sel, 0);
      chk("rst_valid", ch_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_count13", count13, 0);
      chk("rst_locked", locked, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_active", ch_active, ACT_RST);
      rst_n = 1'b1;
      holder = 1'b1;
      repeat (4) step(1'b0, 8'h3C, 1'b0, 1'b0);
      // first lock and one full frame
      pos = 0; ph = 0; step(1'b1, 8'h11, 1'b1, 1'b0);
      run(373);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      chk("ch_active", ch_active, ACT_FRM);
      // early sync once, then again before frame end: realign
      run(147);
      step(1'b1, dat(), 1'b1, 1'b1);
      run(51);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b1);
      run(373);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      // a good sync between two early syncs clears the mismatch count
      run(9);
      step(1'b1, dat(), 1'b1, 1'b1);
      run(363);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      run(19);
      step(1'b1, dat(), 1'b1, 1'b1);
      run(353);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      // sync missing for two frames
      run(373);
      step(1'b0, dat(), 1'b1, 1'b1);
      run(373);
      step(1'b0, dat(), 1'b0, 1'b1);
      repeat (5) step(1'b0, 8'h77, 1'b0, 1'b0);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      // holder dropped mid slot 2, holder beats sync
      run(259);
      holder = 1'b0;
      step(1'b0, dat(), 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b0, 1'b0);
      holder = 1'b1;
      step(1'b1, 8'h55, 1'b0, 1'b0);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      run(50);
      // asynchronous reset mid-frame
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", ch_valid, 0);
      chk("arst_data", ch_data, 0);
      chk("arst_count", count, 0);
      chk("arst_locked", locked, 0);
      chk("arst_sel", ch_sel, 0);
      rst_n = 1'b1;
      q.delete();
      repeat (4) step(1'b0, 8'h99, 1'b0, 1'b0);
      pos = 0; ph = 0; step(1'b1, dat(), 1'b1, 1'b0);
      run(10);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
